// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix codes, frame length, FSM encoding
// and the odd-parity helper used by ps2_frame_receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // True when the data byte plus its parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_sync.sv
// Synchronizes the raw PS/2 clock/data pins into the system clock domain and
// produces a registered falling-edge pulse aligned with the synced data bit.
module ps2_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iKbClock,
    input  logic iKbData,
    output logic synced_data_r,
    output logic fall_r
);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;

    // Synchronizer chains; reset to 1 because an idle PS/2 bus floats high
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], iKbClock};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], iKbData};
        end
    end

    // Falling-edge detect, registered together with the data bit it samples
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_prev_r    <= 1'b1;
            fall_r        <= 1'b0;
            synced_data_r <= 1'b1;
        end else begin
            clk_prev_r    <= clk_sync_r[SYNC_STAGES-1];
            fall_r        <= clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
            synced_data_r <= data_sync_r[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host deframer with F0/E0 prefix folding and frame timeout.
// Define PS2_BREAK_FILTER_EN to swallow key-release events (oBreak tied to 0).
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TMO_W          = 13
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iKbClock,
    input  logic       iKbData,
    output logic [7:0] oReadValue,
    output logic       oKbFlag,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oFrameErr
);

    // Frame is start + data + parity + stop, so the last data index is FRAME_BITS-4
    localparam logic [2:0]       LAST_DATA_BIT = 3'(PS2_FRAME_BITS - 4);
    localparam logic [TMO_W-1:0] TMO_LIMIT     = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             sync_data_s;
    logic             fall_s;
    logic             frame_ok_s;
    logic             tmo_hit_s;

    ps2_state_t       state_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic [TMO_W-1:0] tmo_r;
    logic             break_pend_r;
    logic             ext_pend_r;
    logic [7:0]       read_value_r;
    logic             kb_flag_r;
    logic             break_r;
    logic             ext_r;
    logic             frame_err_r;

    ps2_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock         (Clock),
        .Reset         (Reset),
        .iKbClock      (iKbClock),
        .iKbData       (iKbData),
        .synced_data_r (sync_data_s),
        .fall_r        (fall_s)
    );

    // Stop-bit/parity acceptance and mid-frame timeout detection
    always_comb begin
        frame_ok_s = 1'b0;
        tmo_hit_s  = 1'b0;
        if (sync_data_s && odd_parity_ok(shift_r, parity_r)) begin
            frame_ok_s = 1'b1;
        end else begin
            frame_ok_s = 1'b0;
        end
        if ((state_r != IDLE) && (tmo_r == TMO_LIMIT)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Deframing FSM, prefix folding and registered event outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            tmo_r        <= {TMO_W{1'b0}};
            break_pend_r <= 1'b0;
            ext_pend_r   <= 1'b0;
            read_value_r <= 8'h00;
            kb_flag_r    <= 1'b0;
            break_r      <= 1'b0;
            ext_r        <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            kb_flag_r   <= 1'b0;
            frame_err_r <= 1'b0;
            // A fall always wins over a timeout landing in the same cycle
            if (fall_s) begin
                tmo_r <= {TMO_W{1'b0}};
                case (state_r)
                    IDLE: begin
                        if (!sync_data_s) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                            shift_r   <= 8'h00;
                        end
                    end
                    DATA: begin
                        shift_r[bit_cnt_r] <= sync_data_s;
                        bit_cnt_r          <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == LAST_DATA_BIT) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_r <= sync_data_s;
                        state_r  <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (!frame_ok_s) begin
                            frame_err_r  <= 1'b1;
                            break_pend_r <= 1'b0;
                            ext_pend_r   <= 1'b0;
                        end else if (shift_r == PS2_BREAK_PREFIX) begin
                            break_pend_r <= 1'b1;
                        end else if (shift_r == PS2_EXT_PREFIX) begin
                            ext_pend_r <= 1'b1;
                        end else begin
`ifdef PS2_BREAK_FILTER_EN
                            if (!break_pend_r) begin
                                kb_flag_r    <= 1'b1;
                                read_value_r <= shift_r;
                                ext_r        <= ext_pend_r;
                            end
                            break_r      <= 1'b0;
`else
                            kb_flag_r    <= 1'b1;
                            read_value_r <= shift_r;
                            break_r      <= break_pend_r;
                            ext_r        <= ext_pend_r;
`endif
                            break_pend_r <= 1'b0;
                            ext_pend_r   <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (tmo_hit_s) begin
                state_r      <= IDLE;
                bit_cnt_r    <= 3'd0;
                shift_r      <= 8'h00;
                tmo_r        <= {TMO_W{1'b0}};
                frame_err_r  <= 1'b1;
                break_pend_r <= 1'b0;
                ext_pend_r   <= 1'b0;
            end else if (state_r != IDLE) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end else begin
                tmo_r <= {TMO_W{1'b0}};
            end
        end
    end

    assign oReadValue = read_value_r;
    assign oKbFlag    = kb_flag_r;
    assign oBreak     = break_r;
    assign oExtended  = ext_r;
    assign oFrameErr  = frame_err_r;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: frame-level reference model plus
// directed scenarios with literal expectations. Honours PS2_BREAK_FILTER_EN.
module tb_ps2_frame_receiver;

    localparam int N_SYNC = 2;
    localparam int TMO    = 5000;
    localparam int LAT    = N_SYNC + 2;

    logic       Clock;
    logic       Reset;
    logic       iKbClock;
    logic       iKbData;
    logic [7:0] oReadValue;
    logic       oKbFlag;
    logic       oBreak;
    logic       oExtended;
    logic       oFrameErr;

    ps2_frame_receiver #(
        .SYNC_STAGES    (N_SYNC),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (13)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iKbClock   (iKbClock),
        .iKbData    (iKbData),
        .oReadValue (oReadValue),
        .oKbFlag    (oKbFlag),
        .oBreak     (oBreak),
        .oExtended  (oExtended),
        .oFrameErr  (oFrameErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state (frame level, driven from pin samples)
    logic       prev_clk;
    logic       in_frame;
    int         nbits;
    logic [9:0] bits;
    int         since_fall;
    logic       brk_p;
    logic       ext_p;
    logic       sched_flag [64];
    logic       sched_err  [64];
    logic [7:0] sched_val  [64];
    logic       sched_brk  [64];
    logic       sched_ext  [64];
    logic [7:0] held_val;
    logic       held_brk;
    logic       held_ext;

    // Observation counters for the directed scenarios
    int flag_cnt, err_cnt, last_flag_cyc, last_err_cyc, drop_cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        prev_clk = 1'b1; in_frame = 1'b0; nbits = 0; bits = '0;
        since_fall = 0; brk_p = 1'b0; ext_p = 1'b0;
        held_val = 8'h00; held_brk = 1'b0; held_ext = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sched_flag[i] = 1'b0; sched_err[i] = 1'b0; sched_val[i] = 8'h00;
            sched_brk[i] = 1'b0; sched_ext[i] = 1'b0;
        end
    endtask

    // Consume one pin sample; any resulting event appears LAT-1 edges later
    task automatic model_step();
        logic       ck, d, fall, ok;
        logic [7:0] byte_v;
        int         slot;
        if (!Reset) begin
            model_reset();
            return;
        end
        ck = iKbClock; d = iKbData;
        fall = prev_clk && !ck;
        prev_clk = ck;
        slot = (cyc + N_SYNC + 1) % 64;
        if (fall) begin
            since_fall = 0;
            if (!in_frame) begin
                if (d == 1'b0) begin in_frame = 1'b1; nbits = 0; end
            end else begin
                bits[nbits] = d;
                nbits++;
                if (nbits == 10) begin
                    in_frame = 1'b0;
                    byte_v = bits[7:0];
                    ok = bits[9] && ((($countones(byte_v) + int'(bits[8])) % 2) == 1);
                    if (!ok) begin
                        sched_err[slot] = 1'b1; brk_p = 1'b0; ext_p = 1'b0;
                    end else if (byte_v == 8'hF0) begin
                        brk_p = 1'b1;
                    end else if (byte_v == 8'hE0) begin
                        ext_p = 1'b1;
                    end else begin
`ifdef PS2_BREAK_FILTER_EN
                        if (!brk_p) begin
                            sched_flag[slot] = 1'b1; sched_val[slot] = byte_v;
                            sched_brk[slot] = 1'b0; sched_ext[slot] = ext_p;
                        end
`else
                        sched_flag[slot] = 1'b1; sched_val[slot] = byte_v;
                        sched_brk[slot] = brk_p; sched_ext[slot] = ext_p;
`endif
                        brk_p = 1'b0; ext_p = 1'b0;
                    end
                end
            end
        end else if (in_frame) begin
            since_fall++;
            if (since_fall == TMO) begin
                in_frame = 1'b0; sched_err[slot] = 1'b1; brk_p = 1'b0; ext_p = 1'b0;
            end
        end
    endtask

    task automatic compare();
        int slot;
        if (!Reset) begin
            chk("rst_value", 32'(oReadValue), 32'h0);
            chk("rst_flag", 32'(oKbFlag), 32'h0);
            chk("rst_break", 32'(oBreak), 32'h0);
            chk("rst_ext", 32'(oExtended), 32'h0);
            chk("rst_err", 32'(oFrameErr), 32'h0);
        end else begin
            slot = cyc % 64;
            if (sched_flag[slot]) begin
                held_val = sched_val[slot]; held_brk = sched_brk[slot]; held_ext = sched_ext[slot];
            end
            chk("flag", 32'(oKbFlag), 32'(sched_flag[slot]));
            chk("frame_err", 32'(oFrameErr), 32'(sched_err[slot]));
            chk("read_value", 32'(oReadValue), 32'(held_val));
            chk("break", 32'(oBreak), 32'(held_brk));
            chk("extended", 32'(oExtended), 32'(held_ext));
            sched_flag[slot] = 1'b0; sched_err[slot] = 1'b0;
        end
        if (oKbFlag) begin flag_cnt++; last_flag_cyc = cyc; end
        if (oFrameErr) begin err_cnt++; last_err_cyc = cyc; end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            cyc++;
            model_step();
            @(negedge Clock);
            compare();
        end
    endtask

    task automatic clear_obs();
        flag_cnt = 0; err_cnt = 0; last_flag_cyc = 0; last_err_cyc = 0;
    endtask

    // Drive the first nb bits of a device-to-host frame (bit 0 = start)
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit, input int nb);
        logic [10:0] fr;
        fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nb; i++) begin
            iKbData = fr[i];
            tick(4);
            iKbClock = 1'b0;
            drop_cyc = cyc;
            tick(8);
            iKbClock = 1'b1;
            tick(4);
        end
        iKbData = 1'b1;
        tick(4);
    endtask

    initial begin
        Reset = 1'b0; iKbClock = 1'b1; iKbData = 1'b1;
        model_reset();
        clear_obs();
        drop_cyc = 0;
        #1;
        chk("reset_value", 32'(oReadValue), 32'h00);
        chk("reset_flags", 32'({oKbFlag, oBreak, oExtended, oFrameErr}), 32'h0);
        tick(3);
        Reset = 1'b1;
        tick(5);

        // Plain make code 1D
        clear_obs();
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        tick(12);
        chk("1D_flag_count", 32'(flag_cnt), 32'd1);
        chk("1D_value", 32'(oReadValue), 32'h1D);
        chk("1D_break_ext", 32'({oBreak, oExtended}), 32'h0);
        chk("1D_latency", 32'(last_flag_cyc - drop_cyc), 32'(LAT));

        // Bad start bit: a clock fall with data high is ignored
        clear_obs();
        iKbData = 1'b1; tick(4); iKbClock = 1'b0; tick(8); iKbClock = 1'b1; tick(20);
        chk("badstart_events", 32'(flag_cnt + err_cnt), 32'd0);

        // Release F0 1D
        clear_obs();
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        tick(12);
        chk("F0_1D_value", 32'(oReadValue), 32'h1D);
`ifdef PS2_BREAK_FILTER_EN
        chk("F0_1D_flag_count", 32'(flag_cnt), 32'd0);
        chk("F0_1D_break", 32'(oBreak), 32'h0);
`else
        chk("F0_1D_flag_count", 32'(flag_cnt), 32'd1);
        chk("F0_1D_break", 32'(oBreak), 32'h1);
`endif

        // Extended E0 75, then plain 75
        clear_obs();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        tick(12);
        chk("E0_75_flag_count", 32'(flag_cnt), 32'd1);
        chk("E0_75_value_ext", 32'({oExtended, oBreak, oReadValue}), 32'h275);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        tick(12);
        chk("75_ext_cleared", 32'({oExtended, oReadValue}), 32'h075);

        // Parity error, then a good 1C
        clear_obs();
        send_frame(8'h1D, 1'b1, 1'b1, 11);
        tick(12);
        chk("par_err_flag_count", 32'(flag_cnt), 32'd0);
        chk("par_err_count", 32'(err_cnt), 32'd1);
        chk("par_err_latency", 32'(last_err_cyc - drop_cyc), 32'(LAT));
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        tick(12);
        chk("1C_value", 32'(oReadValue), 32'h1C);

        // Stop-bit error after a pending E0 also clears the pending prefix
        clear_obs();
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h1D, 1'b0, 1'b0, 11);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        tick(12);
        chk("stop_err_count", 32'(err_cnt), 32'd1);
        chk("after_stop_err", 32'({oExtended, oReadValue}), 32'h01D);

        // Timeout: start + 4 data bits then silence
        clear_obs();
        send_frame(8'h1D, 1'b0, 1'b1, 5);
        tick(6000);
        chk("tmo_err_count", 32'(err_cnt), 32'd1);
        chk("tmo_flag_count", 32'(flag_cnt), 32'd0);
        chk("tmo_latency", 32'(last_err_cyc - drop_cyc), 32'(TMO + LAT));
        clear_obs();
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        tick(12);
        chk("post_tmo_flag", 32'({flag_cnt[7:0], oReadValue}), 32'h011D);

        // Reset after data bit 5 of a frame
        send_frame(8'h2A, 1'b0, 1'b1, 7);
        Reset = 1'b0;
        #1;
        chk("midreset_outputs", 32'({oKbFlag, oBreak, oExtended, oFrameErr, oReadValue}), 32'h0);
        iKbClock = 1'b1; iKbData = 1'b1;
        tick(3);
        Reset = 1'b1;
        clear_obs();
        tick(4);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        tick(12);
        chk("post_reset_flag", 32'(flag_cnt), 32'd1);
        chk("post_reset_err", 32'(err_cnt), 32'd0);
        chk("post_reset_value", 32'(oReadValue), 32'h1D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
